// File: rtl/spongent_arbiter_pkg.sv
// Shared FSM state type and phase-counter sizing for the spongent job arbiter.
package spongent_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    // One counter times both the LOAD and RUN phases; it must hold max_cycles-1.
    function automatic int unsigned phase_cnt_width(input int unsigned max_cycles);
        return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/spongent_arbiter_if.sv
// Requester-side job/result bundle of the spongent arbiter (two requesters).
interface spongent_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned N          = 88
);
    logic [1:0]                 req_valid;
    logic [1:0][DATA_WIDTH-1:0] req_msg;
    logic [1:0]                 req_ready;
    logic [1:0]                 rsp_valid;
    logic [N-1:0]               rsp_hash;
    logic                       rsp_timeout;

    modport master (
        output req_valid, req_msg,
        input  req_ready, rsp_valid, rsp_hash, rsp_timeout
    );

    modport slave (
        input  req_valid, req_msg,
        output req_ready, rsp_valid, rsp_hash, rsp_timeout
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: ptr selects which requester has priority this round.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        if (ptr) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end
endmodule

// File: rtl/spongent_arbiter.sv
// Shares one spongent hash core between two requesters: IDLE -> LOAD -> RUN -> DONE.
// Optional RUN-cycle counter on cycle_count: define SPONGENT_ARBITER_CYCLE_COUNT_EN.
module spongent_arbiter
    import spongent_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned N              = 88,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spongent_arbiter_if.slave     bus,
    output logic                  cut_rst,
    output logic [DATA_WIDTH-1:0] cut_msg,
    input  logic [N-1:0]          cut_hash,
    input  logic                  cut_end_hash,
    output logic                  busy,
    output logic [31:0]           cycle_count
);
    localparam int unsigned CNT_W = phase_cnt_width(
        (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       gnt, gnt_q, req_ready_q;
    logic             ptr;
    logic             accept, finish_ok, finish_to;
    logic [N-1:0]     rsp_hash_q;
    logic             rsp_timeout_q;

    rr_arbiter_2 u_rr (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        accept    = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state)
            ST_IDLE: if (|bus.req_valid) begin
                accept  = 1'b1;
                state_n = ST_LOAD;
                cnt_n   = '0;
            end
            ST_LOAD: if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                state_n = ST_RUN;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            // A done flag on the last allowed cycle beats the timeout.
            ST_RUN: if (cut_end_hash) begin
                finish_ok = 1'b1;
                state_n   = ST_DONE;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                finish_to = 1'b1;
                state_n   = ST_DONE;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            gnt_q         <= '0;
            req_ready_q   <= '0;
            ptr           <= 1'b0;
            cut_msg       <= '0;
            rsp_hash_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            req_ready_q <= accept ? gnt : 2'b00;
            if (accept) begin
                gnt_q   <= gnt;
                cut_msg <= gnt[1] ? bus.req_msg[1] : bus.req_msg[0];
                ptr     <= gnt[0];
            end
            if (finish_ok) begin
                rsp_hash_q    <= cut_hash;
                rsp_timeout_q <= 1'b0;
            end else if (finish_to) begin
                rsp_hash_q    <= '0;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = (state == ST_DONE) ? gnt_q : 2'b00;
    assign bus.rsp_hash    = rsp_hash_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign cut_rst         = (state != ST_RUN);
    assign busy            = (state != ST_IDLE);

`ifdef SPONGENT_ARBITER_CYCLE_COUNT_EN
    logic [31:0] run_cnt, run_cnt_inc;

    assign run_cnt_inc = (&run_cnt) ? run_cnt : run_cnt + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            if (accept)               run_cnt <= '0;
            else if (state == ST_RUN) run_cnt <= run_cnt_inc;
            if (finish_ok || finish_to) cycle_count <= run_cnt_inc;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_spongent_arbiter.sv
// Directed self-checking bench for spongent_arbiter with a scripted core model.
module tb_spongent_arbiter;
    localparam int unsigned DW    = 64;
    localparam int unsigned HW    = 88;
    localparam int unsigned RSTC  = 4;
    localparam int unsigned TOC   = 16;
`ifdef SPONGENT_ARBITER_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cut_rst;
    logic [DW-1:0] cut_msg;
    logic [HW-1:0] cut_hash;
    logic          cut_end_hash;
    logic          busy;
    logic [31:0]   cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    spongent_arbiter_if #(.DATA_WIDTH(DW), .N(HW)) bus ();

    spongent_arbiter #(
        .DATA_WIDTH     (DW),
        .N              (HW),
        .RST_CYCLES     (RSTC),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .cut_rst      (cut_rst),
        .cut_msg      (cut_msg),
        .cut_hash     (cut_hash),
        .cut_end_hash (cut_end_hash),
        .busy         (busy),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cc(input int runs);
        return CC_EN ? 32'(runs) : 32'd0;
    endfunction

    // One full job: request, LOAD length, scripted core for RUN, DONE pulse, back to IDLE.
    // end_at = RUN cycle in which the core raises end_hash (0 = never).
    task automatic do_job(input string tag, input logic [1:0] valid,
                          input logic [DW-1:0] m0, input logic [DW-1:0] m1,
                          input int end_at, input logic [HW-1:0] hash,
                          input logic [1:0] exp_gnt, input logic [DW-1:0] exp_msg,
                          input logic exp_to, input int exp_runs);
        int n_load;
        int n_run;
        logic [HW-1:0] exp_hash;
        exp_hash = exp_to ? '0 : hash;
        bus.req_valid  = valid;
        bus.req_msg[0] = m0;
        bus.req_msg[1] = m1;
        @(negedge clk);
        check({tag, ".req_ready"}, bus.req_ready, exp_gnt);
        check({tag, ".cut_msg"}, cut_msg, exp_msg);
        check({tag, ".busy_load"}, busy, 1'b1);
        n_load = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, ".req_ready_drop"}, bus.req_ready, 2'b00);
            if (!cut_rst) break;
            n_load++;
        end
        check({tag, ".load_cycles"}, n_load, RSTC);
        cut_hash = hash;
        n_run = 1;
        for (int i = 0; i < 40; i++) begin
            cut_end_hash = (n_run == end_at);
            @(negedge clk);
            cut_end_hash = 1'b0;
            if (cut_rst) break;
            n_run++;
        end
        cut_hash = {HW{1'b1}};
        check({tag, ".run_cycles"}, n_run, exp_runs);
        check({tag, ".rsp_valid"}, bus.rsp_valid, exp_gnt);
        check({tag, ".rsp_timeout"}, bus.rsp_timeout, exp_to);
        check({tag, ".rsp_hash"}, bus.rsp_hash, exp_hash);
        check({tag, ".cycle_count"}, cycle_count, exp_cc(exp_runs));
        @(negedge clk);
        check({tag, ".rsp_valid_drop"}, bus.rsp_valid, 2'b00);
        check({tag, ".idle_busy"}, busy, 1'b0);
        check({tag, ".hash_hold"}, bus.rsp_hash, exp_hash);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_msg[0] = '0;
        bus.req_msg[1] = '0;
        cut_hash       = '0;
        cut_end_hash   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst.cut_rst", cut_rst, 1'b1);
        check("rst.cut_msg", cut_msg, 64'h0);
        check("rst.req_ready", bus.req_ready, 2'b00);
        check("rst.rsp_valid", bus.rsp_valid, 2'b00);
        check("rst.rsp_hash", bus.rsp_hash, 88'h0);
        check("rst.rsp_timeout", bus.rsp_timeout, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.cycle_count", cycle_count, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Requester 0 alone, core finishes in RUN cycle 10.
        do_job("single", 2'b01, 64'h0123456789ABCDEF, 64'h0, 10,
               88'hC0FFEE_0123456789ABCDEF, 2'b01, 64'h0123456789ABCDEF, 1'b0, 10);

        // Requester 1, core never finishes: timeout after 16 RUN cycles.
        do_job("timeout", 2'b10, 64'h0, 64'h2222_2222_2222_2222, 0,
               88'h77_7777_7777_7777_7777_7777, 2'b10, 64'h2222_2222_2222_2222, 1'b1, TOC);

        // end_hash on the very cycle the timeout would fire.
        do_job("edge", 2'b01, 64'hFEDC_BA98_7654_3210, 64'h0, TOC,
               88'h0BADC0DE_FEEDFACE_CAFE00, 2'b01, 64'hFEDC_BA98_7654_3210, 1'b0, TOC);

        // Reset in the middle of RUN; pointer currently favours requester 1.
        bus.req_valid  = 2'b01;
        bus.req_msg[0] = 64'h3333_3333_3333_3333;
        @(negedge clk);
        check("mid.req_ready", bus.req_ready, 2'b01);
        for (int i = 0; i < 20; i++) begin
            if (!cut_rst) break;
            @(negedge clk);
        end
        check("mid.in_run", cut_rst, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid.busy", busy, 1'b0);
        check("mid.cut_rst", cut_rst, 1'b1);
        check("mid.cut_msg", cut_msg, 64'h0);
        check("mid.rsp_hash", bus.rsp_hash, 88'h0);
        check("mid.rsp_timeout", bus.rsp_timeout, 1'b0);
        check("mid.cycle_count", cycle_count, 32'h0);
        bus.req_valid = 2'b00;
        cut_end_hash  = 1'b1;
        @(negedge clk);
        check("mid.rsp_valid_in_rst", bus.rsp_valid, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        cut_end_hash = 1'b0;
        check("mid.rsp_valid_after", bus.rsp_valid, 2'b00);
        check("mid.busy_after", busy, 1'b0);
        check("mid.req_ready_after", bus.req_ready, 2'b00);

        // Both requesters valid: grants must restart at 0 and alternate.
        do_job("rr0", 2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1,
               88'h11_0000_0000_0000_0000_0001, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1);
        do_job("rr1", 2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 2,
               88'h22_0000_0000_0000_0000_0002, 2'b10, 64'h5555_5555_5555_5555, 1'b0, 2);
        do_job("rr2", 2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1,
               88'h33_0000_0000_0000_0000_0003, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1);
        do_job("rr3", 2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 3,
               88'h44_0000_0000_0000_0000_0004, 2'b10, 64'h5555_5555_5555_5555, 1'b0, 3);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        check("end.busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
